nexi_uart_tx_frame: RTL and testbench
=====================================

Name: nexi_uart_tx_frame

Overview:
Parametrised UART transmitter, successor to the minimal fixed 8N1 TX. It runs on the system clock with an internal baud divider instead of a 1x-bps clock. Data width, parity mode and stop-bit count are configurable. A one-entry holding register behind a valid/ready handshake allows back-to-back frames with no idle gap. It sits between the host-side register/FIFO logic and the TX pad.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
PARITY, 0, 0 = none, 1 = odd, 2 = even; other values are illegal (elaboration error).
STOP_BITS, 1, 1 or 2 stop bits.
CLKS_PER_BIT, 16, clk cycles per bit cell; minimum 2; the counter is $clog2(CLKS_PER_BIT) bits wide.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  asynchronous, active-high reset.
tx_data  in  DATA_BITS  byte to send; sampled only on handshake.
tx_valid  in  1  source has data.
tx_ready  out  1  holding register empty; handshake when tx_valid & tx_ready at a rising edge.
tx_pin  out  1  serial line, idle high; registered output.
busy  out  1  high while a frame is on the line or the holding register is full.

Behaviour:
- Reset (async, immediate, including mid-frame):
  - tx_pin=1, tx_ready=1, busy=0.
  - FSM=IDLE; holding register empty; baud counter=0; bit counter=0.
  - Any partial frame is abandoned; the line goes high at once.
- Holding register (hold_full):
  - Set on handshake, and tx_data is copied into it.
  - Cleared when the FSM loads it into the shift register.
  - tx_ready = ~hold_full (registered state, no combinational path from tx_valid).
  - Handshake and load in the same cycle: the load takes the old content, and hold_full stays 1 with the new data.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_pin=1. If hold_full, go to START on the next edge: load shift reg, clear hold_full, drive tx_pin=0, baud counter=0.
  - START: 1 bit cell of 0, then go to DATA and drive shift[0].
  - DATA: DATA_BITS cells. At each cell end, shift right and drive the next LSB. The parity accumulator XORs each sent bit.
  - After the last data cell, go to PARITY if PARITY!=0, else go to STOP.
  - PARITY: 1 cell. Value is XOR of the data bits for even parity, inverted for odd parity (total ones including the parity bit is odd).
  - STOP: STOP_BITS cells of 1. At the end of the last stop cell:
    - if hold_full, go directly to START (0-cycle gap; tx_pin goes low on the very next cycle);
    - else go to IDLE.
- Bit cell timing:
  - The baud counter counts 0..CLKS_PER_BIT-1.
  - A cell ends when counter==CLKS_PER_BIT-1; the counter then wraps to 0.
  - Every cell lasts exactly CLKS_PER_BIT cycles.
- Frame length: CLKS_PER_BIT*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
- Latency: handshake at edge k (FSM in IDLE) -> tx_pin=0 from edge k+1.
- busy = (FSM!=IDLE) | hold_full.
- A new handshake is accepted while a frame is in progress whenever tx_ready=1. Data is never dropped, and tx_data is never re-sampled outside a handshake.
- tx_valid held with tx_ready=0: no effect; the source must hold its data.

Test Plan:
1. DATA_BITS=8, PARITY=0, STOP_BITS=1, CLKS_PER_BIT=4; send 0xA5.
   - tx_pin low 1 cycle after handshake; cells (4 cycles each): 0,1,0,1,0,0,1,0,1,1.
   - Frame is 40 cycles; busy falls on the cycle after the stop cell ends.
2. Same data with PARITY=2 (even):
   - parity cell=0; frame 44 cycles.
   - With PARITY=1 (odd): parity cell=1.
   - Data 0x01 with even parity: parity cell=1.
3. Back-to-back 0x00 then 0xFF, with tx_valid held high continuously:
   - second handshake accepted 1 cycle after the first frame's load (tx_ready was low for 1 cycle);
   - second start bit begins the cycle right after the first stop cell; no idle-high gap.
4. Assert rst for 1 cycle mid DATA (cell 3 of 0x55):
   - tx_pin=1, tx_ready=1, busy=0 immediately (asynchronously);
   - the next handshake produces a clean full frame.
5. DATA_BITS=7, STOP_BITS=2, PARITY=1, CLKS_PER_BIT=3; send 0x7F:
   - cells 0, 1×7, parity 0, 1, 1; frame 33 cycles.
6. tx_valid asserted while hold_full=1 and a frame is active:
   - no handshake; holding register unchanged;
   - accepted on the first edge after the load clears hold_full; order of bytes on the line is preserved.

Source files
------------

// File: rtl/nexi_uart_tx_frame.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// nexi_uart_tx_frame
// Parametrised UART transmitter with an internal baud divider and a one-entry
// holding register behind a valid/ready handshake. A byte accepted while a
// frame is on the line goes out with no idle gap after the current stop bit(s).
//
// Parameters
//   DATA_BITS     data bits per frame (5..9), sent LSB first
//   PARITY        0 = none, 1 = odd, 2 = even
//   STOP_BITS     1 or 2 stop bits
//   CLKS_PER_BIT  clk cycles per bit cell (>= 2)
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   tx_data   word to send, sampled only on handshake
//   tx_valid  source has data
//   tx_ready  holding register empty (registered)
//   tx_pin    serial line, idle high (registered)
//   busy      frame on the line or holding register full (registered)
// ----------------------------------------------------------------------------
module nexi_uart_tx_frame #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_pin,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    // Reject illegal configurations at elaboration.
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("nexi_uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("nexi_uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("nexi_uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("nexi_uart_tx_frame: CLKS_PER_BIT must be >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q,     state_d;
    logic [CNT_W-1:0]     baud_q,      baud_d;
    logic [BIT_W-1:0]     bit_q,       bit_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic                 par_q,       par_d;
    logic [DATA_BITS-1:0] hold_q;
    logic                 hold_full_q, hold_full_d;
    logic                 tx_pin_d;
    logic                 tx_ready_d;
    logic                 busy_d;

    logic                 handshake;
    logic                 cell_end;
    logic                 load;
    logic                 par_all;

    assign handshake = tx_valid & tx_ready;

    // Next-state, baud/bit counters, shift register and line value.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tx_pin_d = tx_pin;
        cell_end = 1'b0;
        load     = 1'b0;
        par_all  = par_q ^ shift_q[0];

        // Baud counter runs in every non-idle state and wraps at cell end.
        if (state_q != S_IDLE) begin
            if (baud_q == CNT_LAST) begin
                cell_end = 1'b1;
                baud_d   = '0;
            end else begin
                baud_d = baud_q + CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                tx_pin_d = 1'b1;
                baud_d   = '0;
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end

            S_START: begin
                if (cell_end) begin
                    state_d  = S_DATA;
                    bit_d    = '0;
                    tx_pin_d = shift_q[0];
                end
            end

            S_DATA: begin
                if (cell_end) begin
                    par_d = par_all;
                    if (bit_q == DATA_LAST) begin
                        if (PARITY != 0) begin
                            state_d  = S_PARITY;
                            // Odd parity inverts so the total count of ones is odd.
                            tx_pin_d = (PARITY == 1) ? ~par_all : par_all;
                        end else begin
                            state_d  = S_STOP;
                            bit_d    = '0;
                            tx_pin_d = 1'b1;
                        end
                    end else begin
                        bit_d    = bit_q + BIT_W'(1);
                        shift_d  = shift_q >> 1;
                        tx_pin_d = shift_q[1];
                    end
                end
            end

            S_PARITY: begin
                if (cell_end) begin
                    state_d  = S_STOP;
                    bit_d    = '0;
                    tx_pin_d = 1'b1;
                end
            end

            S_STOP: begin
                if (cell_end) begin
                    if (bit_q == STOP_LAST) begin
                        // Pending word chains straight into a new start bit.
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d  = S_IDLE;
                            tx_pin_d = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end

            default: begin
                state_d  = S_IDLE;
                baud_d   = '0;
                tx_pin_d = 1'b1;
            end
        endcase

        // Move the holding register into the shift register and start a frame.
        if (load) begin
            state_d  = S_START;
            baud_d   = '0;
            bit_d    = '0;
            shift_d  = hold_q;
            par_d    = 1'b0;
            tx_pin_d = 1'b0;
        end

        // A handshake wins over a same-cycle load: load takes the old word.
        if (handshake) begin
            hold_full_d = 1'b1;
        end else if (load) begin
            hold_full_d = 1'b0;
        end else begin
            hold_full_d = hold_full_q;
        end

        tx_ready_d = ~hold_full_d;
        busy_d     = (state_d != S_IDLE) | hold_full_d;
    end

    // State register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_pin      <= 1'b1;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            hold_full_q <= hold_full_d;
            tx_pin      <= tx_pin_d;
            tx_ready    <= tx_ready_d;
            busy        <= busy_d;
            if (handshake) begin
                hold_q <= tx_data;
            end
        end
    end

endmodule

// File: tb/tb_nexi_uart_tx_frame.sv
`timescale 1ns/1ps
// Directed bench for nexi_uart_tx_frame: four instances cover 8N1, 8E1, 8O1
// and 7O2 framing; line values are checked every cycle against hand-built
// cell sequences.
module tb_nexi_uart_tx_frame;

    logic clk;
    logic rst;

    // a: 8N1, 4 clk/bit
    logic [7:0] data_a;
    logic       valid_a, ready_a, pin_a, busy_a;
    // e: 8E1, 4 clk/bit
    logic [7:0] data_e;
    logic       valid_e, ready_e, pin_e, busy_e;
    // o: 8O1, 4 clk/bit
    logic [7:0] data_o;
    logic       valid_o, ready_o, pin_o, busy_o;
    // s: 7O2, 3 clk/bit
    logic [6:0] data_s;
    logic       valid_s, ready_s, pin_s, busy_s;

    int total;
    int bad;

    nexi_uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(4)) u_a (
        .clk(clk), .rst(rst), .tx_data(data_a), .tx_valid(valid_a),
        .tx_ready(ready_a), .tx_pin(pin_a), .busy(busy_a));

    nexi_uart_tx_frame #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(4)) u_e (
        .clk(clk), .rst(rst), .tx_data(data_e), .tx_valid(valid_e),
        .tx_ready(ready_e), .tx_pin(pin_e), .busy(busy_e));

    nexi_uart_tx_frame #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(4)) u_o (
        .clk(clk), .rst(rst), .tx_data(data_o), .tx_valid(valid_o),
        .tx_ready(ready_o), .tx_pin(pin_o), .busy(busy_o));

    nexi_uart_tx_frame #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .CLKS_PER_BIT(3)) u_s (
        .clk(clk), .rst(rst), .tx_data(data_s), .tx_valid(valid_s),
        .tx_ready(ready_s), .tx_pin(pin_s), .busy(busy_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        total++; if (pin_a !== 1'b1)   begin bad++; $display("FAIL reset_pin_a got=%b want=1", pin_a); end
        total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL reset_ready_a got=%b want=1", ready_a); end
        total++; if (busy_a !== 1'b0)  begin bad++; $display("FAIL reset_busy_a got=%b want=0", busy_a); end
        total++; if (pin_s !== 1'b1)   begin bad++; $display("FAIL reset_pin_s got=%b want=1", pin_s); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (pin_a !== 1'b1)   begin bad++; $display("FAIL idle_pin_a got=%b want=1", pin_a); end
        total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL idle_ready_a got=%b want=1", ready_a); end
        total++; if (busy_e !== 1'b0)  begin bad++; $display("FAIL idle_busy_e got=%b want=0", busy_e); end
    endtask

    task automatic test_8n1;
        logic [0:9] cells;
        cells   = 10'b0101001011;   // start, A5 LSB first, stop
        data_a  = 8'hA5;
        valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL 8n1_ready_after_hs got=%b want=0", ready_a); end
        total++; if (pin_a !== 1'b1)   begin bad++; $display("FAIL 8n1_pin_at_hs got=%b want=1", pin_a); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            total++; if (pin_a !== cells[4'(i/4)]) begin bad++; $display("FAIL 8n1_pin cyc=%0d got=%b want=%b", i, pin_a, cells[4'(i/4)]); end
            total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL 8n1_busy cyc=%0d got=%b want=1", i, busy_a); end
        end
        @(posedge clk); #1;
        total++; if (busy_a !== 1'b0)  begin bad++; $display("FAIL 8n1_busy_end got=%b want=0", busy_a); end
        total++; if (pin_a !== 1'b1)   begin bad++; $display("FAIL 8n1_pin_end got=%b want=1", pin_a); end
        total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL 8n1_ready_end got=%b want=1", ready_a); end
    endtask

    task automatic test_parity;
        logic [0:10] cells_e;
        logic [0:10] cells_o;
        cells_e = 11'b01010010101;  // A5, even parity 0
        cells_o = 11'b01010010111;  // A5, odd parity 1
        data_e  = 8'hA5;
        data_o  = 8'hA5;
        valid_e = 1'b1;
        valid_o = 1'b1;
        @(posedge clk); #1;
        valid_e = 1'b0;
        valid_o = 1'b0;
        for (int i = 0; i < 44; i++) begin
            @(posedge clk); #1;
            total++; if (pin_e !== cells_e[4'(i/4)]) begin bad++; $display("FAIL even_a5_pin cyc=%0d got=%b want=%b", i, pin_e, cells_e[4'(i/4)]); end
            total++; if (pin_o !== cells_o[4'(i/4)]) begin bad++; $display("FAIL odd_a5_pin cyc=%0d got=%b want=%b", i, pin_o, cells_o[4'(i/4)]); end
        end
        @(posedge clk); #1;
        total++; if (busy_e !== 1'b0) begin bad++; $display("FAIL even_busy_end got=%b want=0", busy_e); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL odd_busy_end got=%b want=0", busy_o); end
    endtask

    task automatic test_parity_one;
        logic [0:10] cells;
        cells   = 11'b01000000011;  // 01, even parity 1
        data_e  = 8'h01;
        valid_e = 1'b1;
        @(posedge clk); #1;
        valid_e = 1'b0;
        for (int i = 0; i < 44; i++) begin
            @(posedge clk); #1;
            total++; if (pin_e !== cells[4'(i/4)]) begin bad++; $display("FAIL even_01_pin cyc=%0d got=%b want=%b", i, pin_e, cells[4'(i/4)]); end
        end
        @(posedge clk); #1;
        total++; if (busy_e !== 1'b0) begin bad++; $display("FAIL even_01_busy_end got=%b want=0", busy_e); end
    endtask

    task automatic test_back_to_back;
        logic [0:19] cells;
        logic        exp_ready;
        cells   = 20'b0000000001_0111111111;
        data_a  = 8'h00;
        valid_a = 1'b1;
        @(posedge clk); #1;
        total++; if (ready_a !== 1'b0) begin bad++; $display("FAIL b2b_ready_first got=%b want=0", ready_a); end
        data_a = 8'hFF;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            exp_ready = (i == 0) || (i >= 40);
            total++; if (pin_a !== cells[5'(i/4)]) begin bad++; $display("FAIL b2b_pin cyc=%0d got=%b want=%b", i, pin_a, cells[5'(i/4)]); end
            total++; if (ready_a !== exp_ready) begin bad++; $display("FAIL b2b_ready cyc=%0d got=%b want=%b", i, ready_a, exp_ready); end
            total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL b2b_busy cyc=%0d got=%b want=1", i, busy_a); end
            if (i == 1) valid_a = 1'b0;
        end
        @(posedge clk); #1;
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL b2b_busy_end got=%b want=0", busy_a); end
        total++; if (pin_a !== 1'b1)  begin bad++; $display("FAIL b2b_pin_end got=%b want=1", pin_a); end
    endtask

    task automatic test_reset_mid_frame;
        logic [0:9] cells;
        cells   = 10'b0101010101;   // start, 55 LSB first, stop
        data_a  = 8'h55;
        valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        // Inside data bit 3 (a zero) of 0x55.
        total++; if (pin_a !== 1'b0) begin bad++; $display("FAIL mid_pin_before_rst got=%b want=0", pin_a); end
        #1 rst = 1'b1;
        #1;
        total++; if (pin_a !== 1'b1)   begin bad++; $display("FAIL mid_rst_pin got=%b want=1", pin_a); end
        total++; if (ready_a !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b want=1", ready_a); end
        total++; if (busy_a !== 1'b0)  begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy_a); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (pin_a !== 1'b1)  begin bad++; $display("FAIL mid_post_rst_pin got=%b want=1", pin_a); end
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL mid_post_rst_busy got=%b want=0", busy_a); end
        valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            total++; if (pin_a !== cells[4'(i/4)]) begin bad++; $display("FAIL mid_refr_pin cyc=%0d got=%b want=%b", i, pin_a, cells[4'(i/4)]); end
        end
        @(posedge clk); #1;
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL mid_refr_busy_end got=%b want=0", busy_a); end
    endtask

    task automatic test_seven_odd_two_stop;
        logic [0:10] cells;
        cells   = 11'b01111111011;  // start, 7F (7 bits), odd parity 0, two stops
        data_s  = 7'h7F;
        valid_s = 1'b1;
        @(posedge clk); #1;
        valid_s = 1'b0;
        for (int i = 0; i < 33; i++) begin
            @(posedge clk); #1;
            total++; if (pin_s !== cells[4'(i/3)]) begin bad++; $display("FAIL 7o2_pin cyc=%0d got=%b want=%b", i, pin_s, cells[4'(i/3)]); end
            total++; if (busy_s !== 1'b1) begin bad++; $display("FAIL 7o2_busy cyc=%0d got=%b want=1", i, busy_s); end
        end
        @(posedge clk); #1;
        total++; if (busy_s !== 1'b0) begin bad++; $display("FAIL 7o2_busy_end got=%b want=0", busy_s); end
        total++; if (pin_s !== 1'b1)  begin bad++; $display("FAIL 7o2_pin_end got=%b want=1", pin_s); end
    endtask

    task automatic test_hold_full;
        logic [0:29] cells;
        logic        exp_ready;
        cells   = 30'b0001111001_0110000111_0100110011;  // 3C, C3, 99
        data_a  = 8'h3C;
        valid_a = 1'b1;
        @(posedge clk); #1;
        data_a = 8'hC3;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk); #1;
            exp_ready = (i == 0) || (i == 40) || (i >= 80);
            total++; if (pin_a !== cells[5'(i/4)]) begin bad++; $display("FAIL hold_pin cyc=%0d got=%b want=%b", i, pin_a, cells[5'(i/4)]); end
            total++; if (ready_a !== exp_ready) begin bad++; $display("FAIL hold_ready cyc=%0d got=%b want=%b", i, ready_a, exp_ready); end
            // Offer 0x99 while the holding register still has C3.
            if (i == 1)  data_a  = 8'h99;
            if (i == 41) valid_a = 1'b0;
        end
        @(posedge clk); #1;
        total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL hold_busy_end got=%b want=0", busy_a); end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        data_a  = '0; valid_a = 1'b0;
        data_e  = '0; valid_e = 1'b0;
        data_o  = '0; valid_o = 1'b0;
        data_s  = '0; valid_s = 1'b0;

        test_reset();
        test_8n1();
        test_parity();
        test_parity_one();
        test_back_to_back();
        test_reset_mid_frame();
        test_seven_odd_two_stop();
        test_hold_full();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
